// File: rtl/lut_shift_ctl.sv
// Serial-load controller and two-port round-robin lookup arbiter for the 8-cell shift-register LUT element.
// Optional LUT_SHADOW_READ_EN: answer lookups from the shadow word while a new table is being shifted in.
module lut_shift_ctl #(
   parameter int SEL_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [2**SEL_W-1:0]   cfg_data,
   output logic                  loaded,
   output logic                  sr_enable,
   output logic                  sr_s,
   output logic [SEL_W-1:0]      sr_abc,
   input  logic                  sr_z,
   input  logic                  req0_valid,
   input  logic [SEL_W-1:0]      req0_sel,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [SEL_W-1:0]      req1_sel,
   output logic                  req1_ready,
   output logic                  resp0_valid,
   output logic                  resp0_data,
   output logic                  resp1_valid,
   output logic                  resp1_data
);

   typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

   state_t               state;
   logic [2**SEL_W-1:0]  shadow;
   logic [SEL_W-1:0]     cnt;
   logic                 ptr;
   logic                 grant_en;
   logic                 gnt0;
   logic                 gnt1;
   logic                 rd0;
   logic                 rd1;

   assign cfg_ready = (state != LOAD);
   assign loaded    = (state == READY);
   assign sr_enable = (state == LOAD);
   // Highest cell first, so the first bit shifted in ends up in the top cell.
   assign sr_s      = (state == LOAD) & shadow[~cnt];

`ifdef LUT_SHADOW_READ_EN
   assign grant_en = (state == READY) || (state == LOAD);
`else
   assign grant_en = (state == READY);
`endif

   // ptr=1 means req1 wins a tie; it always points away from the last winner.
   assign gnt0       = grant_en & req0_valid & (~req1_valid | ~ptr);
   assign gnt1       = grant_en & req1_valid & (~req0_valid |  ptr);
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      sr_abc = '0;
      if (state == READY) begin
         if (gnt0)
            sr_abc = req0_sel;
         else if (gnt1)
            sr_abc = req1_sel;
      end
   end

   always_comb begin
      rd0 = sr_z;
      rd1 = sr_z;
`ifdef LUT_SHADOW_READ_EN
      if (state == LOAD) begin
         rd0 = shadow[req0_sel];
         rd1 = shadow[req1_sel];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         shadow      <= '0;
         cnt         <= '0;
         ptr         <= 1'b0;
         resp0_valid <= 1'b0;
         resp0_data  <= 1'b0;
         resp1_valid <= 1'b0;
         resp1_data  <= 1'b0;
      end else begin
         resp0_valid <= gnt0;
         resp1_valid <= gnt1;
         if (gnt0)
            resp0_data <= rd0;
         if (gnt1)
            resp1_data <= rd1;
         if (gnt0)
            ptr <= 1'b1;
         else if (gnt1)
            ptr <= 1'b0;

         case (state)
            EMPTY, READY: begin
               if (cfg_valid) begin
                  shadow <= cfg_data;
                  cnt    <= '0;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1)
                  state <= READY;
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_shift_ctl.sv
// Directed bench for lut_shift_ctl with a behavioural model of the 8-cell shift-register element.
// Expectations under LUT_SHADOW_READ_EN follow that macro when it is defined for the build.
module tb_lut_shift_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_data;
   logic       loaded;
   logic       sr_enable;
   logic       sr_s;
   logic [2:0] sr_abc;
   logic       sr_z;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_sel, req1_sel;
   logic       req0_ready, req1_ready;
   logic       resp0_valid, resp1_valid;
   logic       resp0_data, resp1_data;

   int errors = 0;
   int checks = 0;

   logic [7:0]  cells;
   logic [12:0] obs;

   localparam logic [12:0] RESET_VEC = 13'b1_0_0_0_000_0_0_0_0_0_0;

   always #5 clk = ~clk;

   // Element model: new bit enters cell 0 and everything moves up one cell.
   always @(posedge clk)
      if (sr_enable)
         cells <= {cells[6:0], sr_s};
   assign sr_z = cells[sr_abc];

   assign obs = {cfg_ready, loaded, sr_enable, sr_s, sr_abc, req0_ready, req1_ready,
                 resp0_valid, resp0_data, resp1_valid, resp1_data};

   lut_shift_ctl #(.SEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .loaded(loaded), .sr_enable(sr_enable), .sr_s(sr_s), .sr_abc(sr_abc), .sr_z(sr_z),
      .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_data(resp0_data),
      .resp1_valid(resp1_valid), .resp1_data(resp1_data)
   );

   task automatic load_table(input logic [7:0] w);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = w;
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
      req0_valid = 1'b1; req0_sel = 3'd3; req1_valid = 1'b1; req1_sel = 3'd5;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, RESET_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_empty();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready, resp0_valid, resp1_valid, loaded} !== 5'b0) begin
            errors++; $display("[TB] FAIL empty_no_grant cycle=%0d got=%b exp=00000", i,
                               {req0_ready, req1_ready, resp0_valid, resp1_valid, loaded});
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_config();
      logic s_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic z_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      @(negedge clk);
      cfg_valid = 1'b1; cfg_data = 8'hA5;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL cfg_ready_empty got=%b exp=1", cfg_ready);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({sr_enable, sr_s, loaded, cfg_ready} !== {1'b1, s_exp[i], 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL load_shift cycle=%0d got=%b exp=%b", i,
                               {sr_enable, sr_s, loaded, cfg_ready}, {1'b1, s_exp[i], 2'b00});
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({loaded, sr_enable, cfg_ready} !== 3'b101) begin
         errors++; $display("[TB] FAIL load_done got=%b exp=101", {loaded, sr_enable, cfg_ready});
      end
      for (int s = 0; s < 8; s++) begin
         req0_valid = 1'b1; req0_sel = 3'(s);
         #1;
         checks++;
         if ({req0_ready, sr_abc} !== {1'b1, 3'(s)}) begin
            errors++; $display("[TB] FAIL lookup_grant sel=%0d got=%b exp=%b", s,
                               {req0_ready, sr_abc}, {1'b1, 3'(s)});
         end
         @(negedge clk);
         req0_valid = 1'b0;
         #1;
         checks++;
         if ({resp0_valid, resp0_data, resp1_valid} !== {1'b1, z_exp[s], 1'b0}) begin
            errors++; $display("[TB] FAIL lookup_resp sel=%0d got=%b exp=%b", s,
                               {resp0_valid, resp0_data, resp1_valid}, {1'b1, z_exp[s], 1'b0});
         end
      end
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      load_table(8'h08);
      req0_valid = 1'b1; req0_sel = 3'd3;
      req1_valid = 1'b1; req1_sel = 3'd4;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready, sr_abc} !==
             {(k % 2 == 0), (k % 2 == 1), ((k % 2 == 0) ? 3'd3 : 3'd4)}) begin
            errors++; $display("[TB] FAIL arb_grant cycle=%0d got=%b exp=%b", k,
                               {req0_ready, req1_ready, sr_abc},
                               {(k % 2 == 0), (k % 2 == 1), ((k % 2 == 0) ? 3'd3 : 3'd4)});
         end
         if (k > 0) begin
            checks++;
            if ({resp0_valid, resp1_valid} !== {(k % 2 == 1), (k % 2 == 0)} ||
                (resp0_valid === 1'b1 && resp0_data !== 1'b1) ||
                (resp1_valid === 1'b1 && resp1_data !== 1'b0)) begin
               errors++; $display("[TB] FAIL arb_resp cycle=%0d got=%b exp_valid=%b data0=1 data1=0", k,
                                  {resp0_valid, resp0_data, resp1_valid, resp1_data},
                                  {(k % 2 == 1), (k % 2 == 0)});
            end
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      checks++;
      if ({resp0_valid, resp1_valid, resp1_data} !== 3'b010) begin
         errors++; $display("[TB] FAIL arb_last_resp got=%b exp=010", {resp0_valid, resp1_valid, resp1_data});
      end
   endtask

   task automatic test_reconfig();
      load_table(8'h00);
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      req0_valid = 1'b1; req0_sel = 3'd0;
      #1;
      checks++;
      if ({req0_ready, cfg_ready, loaded} !== 3'b111) begin
         errors++; $display("[TB] FAIL reconfig_hs_grant got=%b exp=111", {req0_ready, cfg_ready, loaded});
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (i == 0) begin
            checks++;
            if ({resp0_valid, resp0_data} !== 2'b10) begin
               errors++; $display("[TB] FAIL reconfig_hs_resp got=%b exp=10", {resp0_valid, resp0_data});
            end
         end else begin
            checks++;
`ifdef LUT_SHADOW_READ_EN
            if ({resp0_valid, resp0_data} !== 2'b11) begin
               errors++; $display("[TB] FAIL reconfig_load_resp cycle=%0d got=%b exp=11", i, {resp0_valid, resp0_data});
            end
`else
            if (resp0_valid !== 1'b0) begin
               errors++; $display("[TB] FAIL reconfig_load_resp cycle=%0d got=%b exp=0", i, resp0_valid);
            end
`endif
         end
         checks++;
`ifdef LUT_SHADOW_READ_EN
         if ({req0_ready, sr_abc, sr_enable} !== 5'b1_000_1) begin
            errors++; $display("[TB] FAIL reconfig_load_grant cycle=%0d got=%b exp=10001", i, {req0_ready, sr_abc, sr_enable});
         end
`else
         if ({req0_ready, sr_abc, sr_enable} !== 5'b0_000_1) begin
            errors++; $display("[TB] FAIL reconfig_load_grant cycle=%0d got=%b exp=00001", i, {req0_ready, sr_abc, sr_enable});
         end
`endif
         @(negedge clk);
      end
      #1;
      checks++;
      if ({req0_ready, loaded} !== 2'b11) begin
         errors++; $display("[TB] FAIL reconfig_ready_grant got=%b exp=11", {req0_ready, loaded});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({resp0_valid, resp0_data} !== 2'b11) begin
         errors++; $display("[TB] FAIL reconfig_new_data got=%b exp=11", {resp0_valid, resp0_data});
      end
   endtask

   task automatic test_load_lookup();
      load_table(8'h00);
      cfg_valid = 1'b1; cfg_data = 8'h80;
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      req1_valid = 1'b1; req1_sel = 3'd7;
`ifdef LUT_SHADOW_READ_EN
      #1;
      checks++;
      if ({req1_ready, sr_abc} !== 4'b1_000) begin
         errors++; $display("[TB] FAIL shadow_grant got=%b exp=1000", {req1_ready, sr_abc});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++;
      if ({resp1_valid, resp1_data} !== 2'b11) begin
         errors++; $display("[TB] FAIL shadow_resp got=%b exp=11", {resp1_valid, resp1_data});
      end
      repeat (5) @(negedge clk);
`else
      for (int j = 2; j < 8; j++) begin
         #1;
         checks++;
         if (req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL load_no_grant cycle=%0d got=%b exp=0", j, req1_ready);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({req1_ready, sr_abc} !== 4'b1_111) begin
         errors++; $display("[TB] FAIL held_req_grant got=%b exp=1111", {req1_ready, sr_abc});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++;
      if ({resp1_valid, resp1_data} !== 2'b11) begin
         errors++; $display("[TB] FAIL held_req_resp got=%b exp=11", {resp1_valid, resp1_data});
      end
`endif
   endtask

   task automatic test_reset_midload();
      @(negedge clk);
      cfg_valid = 1'b1; cfg_data = 8'hA5;
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_sel = 3'd2;
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("[TB] FAIL midload_reset got=%b exp=%b", obs, RESET_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({req0_ready, resp0_valid, loaded, sr_enable} !== 4'b0) begin
            errors++; $display("[TB] FAIL midload_empty cycle=%0d got=%b exp=0000", i,
                               {req0_ready, resp0_valid, loaded, sr_enable});
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      load_table(8'hA5);
      req0_valid = 1'b1; req0_sel = 3'd2;
      #1;
      checks++;
      if ({req0_ready, loaded} !== 2'b11) begin
         errors++; $display("[TB] FAIL reload_grant got=%b exp=11", {req0_ready, loaded});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({resp0_valid, resp0_data} !== 2'b11) begin
         errors++; $display("[TB] FAIL reload_resp got=%b exp=11", {resp0_valid, resp0_data});
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_empty();
      test_config();
      test_arbitration();
      test_reconfig();
      test_load_lookup();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lut_shift_ctl.md
# lut_shift_ctl

Controller for the 8-cell serial-load lookup element: an 8-bit shift register loaded one bit per cycle through `enable`/`S`, read through the 3-bit `{A,B,C}` select mux output `Z`. It serializes an 8-bit configuration word into the element so that cell i holds `cfg_data[i]`. It also shares the read port between two lookup requesters with round-robin arbitration and returns one registered result per granted request.

## Interface
- `SEL_W`, 3: select width; the element has `2**SEL_W` = 8 cells. Only 3 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: configuration word offered.
- `cfg_ready` output 1: controller accepts a configuration word.
- `cfg_data` input 8: table contents; bit i is the value to be returned for select i.
- `loaded` output 1: element holds a complete table.
- `sr_enable` output 1: drives the element's `enable`.
- `sr_s` output 1: drives the element's `S`.
- `sr_abc` output 3: drives `{A,B,C}`; `sr_abc[2]`=A.
- `sr_z` input 1: element's `Z`.
- `req0_valid`, `req1_valid` input 1: lookup requests.
- `req0_sel`, `req1_sel` input 3: cell index.
- `req0_ready`, `req1_ready` output 1: request granted this cycle.
- `resp0_valid`, `resp1_valid` output 1: result strobe, one cycle wide.
- `resp0_data`, `resp1_data` output 1: looked-up bit.

## Operation
- FSM states: EMPTY (reset state, no table), LOAD, READY.
- `cfg_ready` = 1 in EMPTY and READY, 0 in LOAD. A configuration handshake (`cfg_valid & cfg_ready`) copies `cfg_data` into the shadow register, clears the bit counter and enters LOAD.
- LOAD: `sr_enable`=1 and `sr_s`=`shadow[7-cnt]` for cnt = 0..7, so bit 7 is shifted first and ends in cell 7. The edge with cnt=7 enters READY. The load takes exactly 8 cycles.
- `loaded` = 1 only in READY. It is 0 in EMPTY and in LOAD.
- `sr_enable`=0 outside LOAD, so the table is held indefinitely.
- Lookups are granted only when state is READY. This includes the cycle of a new configuration handshake, because the table is unchanged until the next edge.
- Arbitration:
  - If only one request is valid, it is granted.
  - If both are valid, the requester not granted last is granted, and the pointer toggles on every grant.
  - Reset sets the pointer so that req0 wins the first tie.
  - At most one of `req0_ready`/`req1_ready` is high.
- `sr_abc` = selected `reqN_sel` in a granted cycle, else 3'b000.
- A result is returned one cycle after its grant: `respN_data` = `sr_z` sampled at the grant edge and `respN_valid` = 1 for one cycle. Back-to-back grants give back-to-back responses.
- Requests made in EMPTY or LOAD see `reqN_ready`=0. A requester holds `valid` and `sel` until it is granted.
- Reset is asynchronous and valid at any point, including mid-load. All outputs go to their reset values and the state goes to EMPTY. The element's contents are then undefined, and a new configuration is required before any lookup is granted.

## Timing
- Reset values: `cfg_ready`=1, `loaded`=0, `sr_enable`=0, `sr_s`=0, `sr_abc`=0, all `reqN_ready`=0, all `respN_valid`=0, all `respN_data`=0.
- `cfg_ready`, `loaded`, `sr_enable` and `sr_s` are decoded from registered state only.
- `reqN_ready` and `sr_abc` are combinational from the request inputs and registered state.
- Configuration handshake at edge T: `sr_enable` is high in cycles T..T+7, and `loaded` rises after edge T+8.
- Lookup latency: grant cycle t, `resp` visible in cycle t+1.
- Throughput is one lookup per cycle in READY.

## Configuration
- `LUT_SHADOW_READ_EN`:
  - Defined: in LOAD, lookups are still arbitrated and granted. Each one is answered from the shadow register (`respN_data` = `shadow[sel]`) with the same 1-cycle latency, and `sr_abc` is held at 0.
  - Undefined: no grants are issued in LOAD, as described under Operation.
  - In both cases EMPTY grants nothing.

## Test plan
- Reset, then configure 8'hA5 -> `sr_enable` high for 8 consecutive cycles with `sr_s` = 1,0,1,0,0,1,0,1. After that `loaded`=1, and lookups of sel 0..7 return 1,0,1,0,0,1,0,1.
- Both requesters valid continuously in READY (req0_sel=3, req1_sel=4, table 8'h08) -> grants alternate req0, req1, req0, …, starting with req0. Responses are resp0_data=1 and resp1_data=0, each one cycle after its grant.
- Reconfigure with 8'hFF while req0 (sel=0, table 8'h00) is valid -> the handshake cycle grants req0 and returns 0. The next 8 cycles grant nothing (macro undefined). After that, lookups return 1.
- With `LUT_SHADOW_READ_EN` defined, reconfigure to 8'h80 from 8'h00 and request sel=7 in the third load cycle -> granted immediately and resp_data=1 one cycle later.
- Assert `rst_n` low during load cycle 4 -> outputs go to their reset values immediately and `loaded` stays 0. Requests are not granted until a new 8-cycle load completes.
- Request in EMPTY after reset -> `reqN_ready` stays 0 and no `respN_valid` appears.
